// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types for the multi-cycle data-memory responder
// Optional range checking is selected in dmem_responder by DMEM_RANGE_CHECK_EN.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int WORD_BYTES = 4;
   localparam int IDX_W      = 30;

   typedef struct packed {
      logic             write;
      logic [IDX_W-1:0] index;
      logic [31:0]      wdata;
      logic [3:0]       byte_en;
   } req_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port byte-enable RAM, write and read registered on one edge
// Only the read register is reset; the storage array keeps its contents.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_en,
   input  logic          i_we,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_en && i_we) begin
         for (int b = 0; b < WORD_BYTES; b++) begin
            if (i_be[b]) begin
               r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   // Holds across stores and idle cycles so the last load stays visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if (i_en && !i_we) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - valid/ready data-memory target with programmable wait states
// Define DMEM_RANGE_CHECK_EN to flag (and suppress) accesses at or above DEPTH*4.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_valid,
   input  logic        i_req_write,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic [3:0]  i_req_byte_en,
   output logic        o_req_ready,
   output logic        o_resp_valid,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_error,
   output logic        o_stall
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   req_t        r_req;
   req_t        w_req_live;
   req_t        w_cmd;
   logic        r_oor;
   logic        w_oor_live;
   logic        w_cmd_oor;
   logic        w_accept;
   logic        w_commit;
   logic [31:0] w_rdata;
   logic        w_unused_bits;

   assign w_req_live = '{write:   i_req_write,
                         index:   i_req_addr[31:2],
                         wdata:   i_req_wdata,
                         byte_en: i_req_byte_en};

`ifdef DMEM_RANGE_CHECK_EN
   assign w_oor_live = ({1'b0, i_req_addr} >= 33'(DEPTH * WORD_BYTES));
`else
   assign w_oor_live = 1'b0;
`endif

   // With no wait states the commit edge is the accepting edge, so the
   // captured registers are not yet loaded and the live request is used.
   assign w_cmd     = (WAIT_STATES == 0) ? w_req_live : r_req;
   assign w_cmd_oor = (WAIT_STATES == 0) ? w_oor_live : r_oor;

   assign o_req_ready = (r_state != WAIT);
   assign w_accept    = i_req_valid & o_req_ready;
   assign o_stall     = i_req_valid & ~o_req_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_commit    = 1'b0;
      case (r_state)
         IDLE, RESP: begin
            if (w_accept) begin
               if (WAIT_STATES == 0) begin
                  w_state_nxt = RESP;
                  w_commit    = 1'b1;
               end else begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = CNT_INIT;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = RESP;
               w_commit    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_req   <= '0;
         r_oor   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_req <= w_req_live;
            r_oor <= w_oor_live;
         end
      end
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_commit & ~w_cmd_oor),
      .i_we    (w_cmd.write),
      .i_be    (w_cmd.byte_en),
      .i_addr  (w_cmd.index[AW-1:0]),
      .i_wdata (w_cmd.wdata),
      .o_rdata (w_rdata)
   );

   assign o_resp_valid = (r_state == RESP);

`ifdef DMEM_RANGE_CHECK_EN
   logic r_resp_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp_err <= 1'b0;
      end else begin
         r_resp_err <= w_commit & w_cmd_oor;
      end
   end

   assign o_resp_error = r_resp_err;
   assign o_resp_rdata = r_resp_err ? 32'd0 : w_rdata;
`else
   assign o_resp_error = 1'b0;
   assign o_resp_rdata = w_rdata;
`endif

   // Address bits outside the word index, kept only to document that they are dropped.
   assign w_unused_bits = ^{i_req_addr[1:0], w_cmd.index[IDX_W-1:AW], r_req, r_oor};

endmodule
